// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and owner codes.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam logic OWNER_REQ0 = 1'b0;
  localparam logic OWNER_REQ1 = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester handshakes and transmitter control seen by the arbiter.
// slave = arbiter side, master = requesters/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int ANCHO = 8
);
  logic             req0_valid_i;
  logic [ANCHO-1:0] req0_data_i;
  logic             req0_ready_o;
  logic             req1_valid_i;
  logic [ANCHO-1:0] req1_data_i;
  logic             req1_ready_o;
  logic             tx_busy_i;
  logic             tx_done_i;
  logic             tx_start_o;
  logic [ANCHO-1:0] tx_data_o;
  logic             sel_o;
  logic             timeout_o;

  modport slave (
    input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, tx_busy_i, tx_done_i,
    output req0_ready_o, req1_ready_o, tx_start_o, tx_data_o, sel_o, timeout_o
  );

  modport master (
    output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, tx_busy_i, tx_done_i,
    input  req0_ready_o, req1_ready_o, tx_start_o, tx_data_o, sel_o, timeout_o
  );
endinterface

// File: rtl/uart_rr_picker.sv
// Two-way round-robin picker: on a tie the requester that did not win last time goes.
module uart_rr_picker
  import uart_arb_pkg::*;
(
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic winner_o,
  output logic any_valid_o
);

  always_comb begin
    any_valid_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      winner_o = ~last_i;
    end else if (valid1_i) begin
      winner_o = OWNER_REQ1;
    end else begin
      winner_o = OWNER_REQ0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between two requesters.
// Optional watchdog on WAIT_DONE enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int ANCHO       = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  uart_tx_arbiter_if.slave   bus,
  output arb_state_e         state_o
);

  arb_state_e       r_state;
  arb_state_e       w_next;
  logic [ANCHO-1:0] r_data;
  logic             r_sel;
  logic             r_last;

  logic w_winner;
  logic w_any;
  logic w_accept;
  logic w_release;
  logic w_start;
  logic w_timeout;
  logic w_ready0;
  logic w_ready1;

  uart_rr_picker u_picker (
    .valid0_i    (bus.req0_valid_i),
    .valid1_i    (bus.req1_valid_i),
    .last_i      (r_last),
    .winner_o    (w_winner),
    .any_valid_o (w_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter restarts while in START so it reads zero on the first WAIT_DONE cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_state == START) begin
      r_cnt <= '0;
    end else if (r_state == WAIT_DONE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Handshake: ready is combinational and goes to at most one requester, only in
  // IDLE with the transmitter not busy; a transfer is valid & ready on that cycle,
  // and the data is sampled only then. Dropping valid before ready has no effect.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_release = 1'b0;
    w_start   = 1'b0;
    w_timeout = 1'b0;
    w_ready0  = 1'b0;
    w_ready1  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.tx_busy_i && w_any) begin
          w_accept = 1'b1;
          w_ready0 = (w_winner == OWNER_REQ0);
          w_ready1 = (w_winner == OWNER_REQ1);
          w_next   = START;
        end
      end
      START: begin
        w_start = 1'b1;
        w_next  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done_i) begin
          w_release = 1'b1;
          w_next    = IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_release = 1'b1;
          w_next    = IDLE;
        end
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_sel   <= OWNER_REQ0;
      r_last  <= OWNER_REQ1;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_data <= (w_winner == OWNER_REQ1) ? bus.req1_data_i : bus.req0_data_i;
        r_sel  <= w_winner;
      end
      if (w_release) begin
        r_last <= r_sel;
      end
    end
  end

  // Ready is masked by reset so requesters never see a grant while it is held.
  assign bus.req0_ready_o = w_ready0 & ~rst_i;
  assign bus.req1_ready_o = w_ready1 & ~rst_i;
  assign bus.tx_start_o   = w_start;
  assign bus.tx_data_o    = r_data;
  assign bus.sel_o        = r_sel;
  assign bus.timeout_o    = w_timeout;
  assign state_o          = r_state;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two requesters, for example the CPU store path and a debug/echo source.
- Arbitrates round-robin with a valid/ready handshake.
- Latches the winning byte and drives the transmit select.
- Issues a one-cycle start pulse, then holds ownership until the transmitter reports completion.

Parameters:
- ANCHO, 8: width of the data word forwarded to the transmitter.
- TIMEOUT_CYC, 200000: watchdog limit in clock cycles. Used only when UART_ARB_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- req0_valid_i  in  1  requester 0 has data
- req0_data_i  in  ANCHO  requester 0 data
- req0_ready_o  out  1  requester 0 data accepted this cycle (when valid)
- req1_valid_i  in  1  requester 1 has data
- req1_data_i  in  ANCHO  requester 1 data
- req1_ready_o  out  1  requester 1 data accepted this cycle (when valid)
- tx_busy_i  in  1  transmitter shifting
- tx_done_i  in  1  one-cycle pulse, frame finished
- tx_start_o  out  1  one-cycle start pulse to transmitter
- tx_data_o  out  ANCHO  latched data to transmitter
- sel_o  out  1  current owner: 0 = req0, 1 = req1
- timeout_o  out  1  one-cycle watchdog pulse; tied 0 without macro

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous, active-high.
- Reset values:
  - state = IDLE
  - tx_start_o = 0, tx_data_o = 0, sel_o = 0
  - both ready outputs = 0, timeout_o = 0
  - last_q = 1, so req0 wins the first tie.
- Reset mid-operation abandons the frame; no start pulse is emitted afterwards.
- FSM states: IDLE, START, WAIT_DONE.
- IDLE:
  - If tx_busy_i = 1, both ready outputs are 0.
  - Otherwise, ready is asserted combinationally to exactly one requester:
    - only one valid: that requester;
    - both valid: the one ≠ last_q;
    - none valid: neither.
  - Transfer occurs on valid & ready. Then capture the data into tx_data_o, set sel_o to the winner, and go to START.
  - tx_done_i is ignored in IDLE.
- START:
  - tx_start_o = 1 for exactly this cycle; both ready outputs = 0.
  - Unconditionally go to WAIT_DONE.
  - A tx_done_i pulse in this cycle is ignored.
- WAIT_DONE:
  - Ready outputs = 0.
  - On tx_done_i: set last_q = sel_o and go to IDLE.
  - tx_data_o and sel_o hold until the next accept.
- Latency:
  - Accept in cycle N, tx_start_o in cycle N+1.
  - After tx_done_i in cycle M, a new accept is possible in cycle M+1 (if tx_busy_i = 0).
- Valid rules:
  - A requester may drop valid before ready without penalty; no transfer occurs.
  - Data is sampled only on the accept cycle.
- Fairness: under continuous contention the grants alternate 0,1,0,1…; neither requester waits more than one frame.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle there.
  - If it reaches TIMEOUT_CYC-1 without tx_done_i: pulse timeout_o for one cycle, set last_q = sel_o, go to IDLE.
  - If tx_done_i and timeout fall on the same cycle, tx_done_i wins and there is no timeout pulse.
  - The counter width is $clog2(TIMEOUT_CYC).
- Undefined: no counter; timeout_o is constant 0; WAIT_DONE waits indefinitely.

Decomposition:
- Shared package uart_arb_pkg holds:
  - state enum arb_state_e {IDLE, START, WAIT_DONE};
  - owner constants OWNER_REQ0 = 1'b0, OWNER_REQ1 = 1'b1.
- Sub-module uart_rr_picker: purely combinational.
  - Inputs: two valids and last_q.
  - Outputs: winner index and any-valid flag.
  - Reusable for other shared peripherals.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst_i asynchronously during WAIT_DONE.
  - Required: all outputs 0 immediately; after release, the first tie grants req0.
- Single request:
  - Stimulus: req0_valid_i = 1, data 8'hA5, tx_busy_i = 0.
  - Required: req0_ready_o = 1 in the same cycle; tx_start_o pulses the next cycle with tx_data_o = A5 and sel_o = 0; no second pulse until tx_done_i.
- Contention:
  - Stimulus: both valid continuously (req0 = 8'h11, req1 = 8'h22), with tx_done_i 10 cycles after each start.
  - Required: transmitted sequence 11, 22, 11, 22.
- Busy gating and ignored done:
  - Stimulus: tx_busy_i = 1 in IDLE with req1_valid_i = 1; separately, a tx_done_i pulse in IDLE.
  - Required: no ready while busy; the idle tx_done_i causes no state change.
- Watchdog (macro defined, TIMEOUT_CYC = 16):
  - Stimulus: accept a byte, never pulse tx_done_i.
  - Required: timeout_o pulses 16 cycles after entry to WAIT_DONE; the next request is accepted afterwards.
  - Also: with tx_done_i coincident with the limit cycle, no timeout pulse.
